// File: rtl/wb_gpio_bank.sv
// Wishbone-slave GPIO bank: register-driven pad outputs and enables, synchronised
// pad inputs, and per-pin edge-triggered interrupt status with W1C clearing.
module wb_gpio_bank #(
  parameter int          NUM_IO      = 16,
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic [31:0]       wbs_dat_o,
  output logic              wbs_ack_o,
  input  logic [NUM_IO-1:0] io_in,
  output logic [NUM_IO-1:0] io_out,
  output logic [NUM_IO-1:0] io_oeb,
  output logic              irq
);

  localparam logic [7:0] OFF_DOUT = 8'h00;
  localparam logic [7:0] OFF_OEB  = 8'h04;
  localparam logic [7:0] OFF_DIN  = 8'h08;
  localparam logic [7:0] OFF_IEN  = 8'h0C;
  localparam logic [7:0] OFF_STAT = 8'h10;
  localparam logic [7:0] OFF_EDGE = 8'h14;

  logic [NUM_IO-1:0] data_out_q, data_out_d;
  logic [NUM_IO-1:0] oeb_q, oeb_d;
  logic [NUM_IO-1:0] irq_en_q, irq_en_d;
  logic [NUM_IO-1:0] irq_status_q, irq_status_d;
  logic [NUM_IO-1:0] irq_edge_q, irq_edge_d;
  logic [NUM_IO-1:0] sync_q [SYNC_STAGES];
  logic [NUM_IO-1:0] sync_d [SYNC_STAGES];
  logic [NUM_IO-1:0] prev_q, prev_d;
  logic              ack_q, ack_d;
  logic [31:0]       dat_q, dat_d;

  logic              hit, req, wr_en;
  logic [31:0]       lane_mask;
  logic [NUM_IO-1:0] wmask, wdata, din, hw_set;
  logic [31:0]       rdata;
  logic              unused_bits;

  assign hit   = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  // The !ack term forces a one-cycle gap, so a held request acks every other cycle.
  assign req   = wbs_cyc_i & wbs_stb_i & hit & ~ack_q;
  assign wr_en = req & wbs_we_i;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_mask[8*gi +: 8] = {8{wbs_sel_i[gi]}};
    end
  endgenerate

  assign wmask       = lane_mask[NUM_IO-1:0];
  assign wdata       = wbs_dat_i[NUM_IO-1:0] & wmask;
  assign unused_bits = ^{wbs_dat_i, lane_mask};
  assign din         = sync_q[SYNC_STAGES-1];

  generate
    for (gi = 0; gi < NUM_IO; gi++) begin : g_edge
      assign hw_set[gi] = irq_edge_q[gi] ? (prev_q[gi] & ~din[gi])
                                         : (din[gi] & ~prev_q[gi]);
    end
  endgenerate

  always_comb begin
    data_out_d   = data_out_q;
    oeb_d        = oeb_q;
    irq_en_d     = irq_en_q;
    irq_status_d = irq_status_q;
    irq_edge_d   = irq_edge_q;
    sync_d[0]    = io_in;
    for (int s = 1; s < SYNC_STAGES; s++) sync_d[s] = sync_q[s-1];
    prev_d       = din;
    rdata        = 32'h0;

    if (wr_en) begin
      case (wbs_adr_i[7:0])
        OFF_DOUT: data_out_d   = (data_out_q & ~wmask) | wdata;
        OFF_OEB:  oeb_d        = (oeb_q & ~wmask) | wdata;
        OFF_IEN:  irq_en_d     = (irq_en_q & ~wmask) | wdata;
        OFF_STAT: irq_status_d = irq_status_q & ~wdata;
        OFF_EDGE: irq_edge_d   = (irq_edge_q & ~wmask) | wdata;
        default:  ;
      endcase
    end
    // Applied after the clear so a same-cycle hardware set wins.
    irq_status_d = irq_status_d | hw_set;

    case (wbs_adr_i[7:0])
      OFF_DOUT: rdata[NUM_IO-1:0] = data_out_q;
      OFF_OEB:  rdata[NUM_IO-1:0] = oeb_q;
      OFF_DIN:  rdata[NUM_IO-1:0] = din;
      OFF_IEN:  rdata[NUM_IO-1:0] = irq_en_q;
      OFF_STAT: rdata[NUM_IO-1:0] = irq_status_q;
      OFF_EDGE: rdata[NUM_IO-1:0] = irq_edge_q;
      default:  rdata = 32'h0;
    endcase

    ack_d = req;
    dat_d = (req & ~wbs_we_i) ? rdata : 32'h0;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      data_out_q   <= '0;
      oeb_q        <= '1;
      irq_en_q     <= '0;
      irq_status_q <= '0;
      irq_edge_q   <= '0;
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      prev_q       <= '0;
      ack_q        <= 1'b0;
      dat_q        <= 32'h0;
    end else begin
      data_out_q   <= data_out_d;
      oeb_q        <= oeb_d;
      irq_en_q     <= irq_en_d;
      irq_status_q <= irq_status_d;
      irq_edge_q   <= irq_edge_d;
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= sync_d[s];
      prev_q       <= prev_d;
      ack_q        <= ack_d;
      dat_q        <= dat_d;
    end
  end

  assign io_out    = data_out_q;
  assign io_oeb    = oeb_q;
  assign irq       = |(irq_status_q & irq_en_q);
  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;

endmodule

// File: tb/tb_wb_gpio_bank.sv
// Bench for wb_gpio_bank: directed scenarios plus randomized traffic checked
// against a cycle-level behavioural model of the register bank and input path.
module tb_wb_gpio_bank;
  localparam int          SYNC = 2;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk, rst;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat_i, dat_o;
  logic        ack;
  logic [15:0] io_in, io_out, io_oeb;
  logic        irq;

  logic        cyc5, stb5, we5;
  logic [3:0]  sel5;
  logic [31:0] adr5, wdat5, rdat5;
  logic        ack5;
  logic [4:0]  io_in5, io_out5, io_oeb5;
  logic        irq5;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model state
  logic [15:0] m_dout, m_oeb, m_en, m_stat, m_edge, m_last_set;
  logic [15:0] hist [0:SYNC];   // hist[j] = io_in sampled j+1 edges ago
  logic [7:0]  b_off;
  logic [31:0] m_rd_exp;

  wb_gpio_bank #(.NUM_IO(16), .BASE_ADDR(BASE), .SYNC_STAGES(SYNC)) u_dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc), .wbs_stb_i(stb),
    .wbs_we_i(we), .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat_i),
    .wbs_dat_o(dat_o), .wbs_ack_o(ack), .io_in(io_in), .io_out(io_out),
    .io_oeb(io_oeb), .irq(irq));

  wb_gpio_bank #(.NUM_IO(5), .BASE_ADDR(BASE), .SYNC_STAGES(SYNC)) u_dut5 (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc5), .wbs_stb_i(stb5),
    .wbs_we_i(we5), .wbs_sel_i(sel5), .wbs_adr_i(adr5), .wbs_dat_i(wdat5),
    .wbs_dat_o(rdat5), .wbs_ack_o(ack5), .io_in(io_in5), .io_out(io_out5),
    .io_oeb(io_oeb5), .irq(irq5));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model_read(input logic [7:0] off);
    case (off)
      8'h00:   return {16'h0, m_dout};
      8'h04:   return {16'h0, m_oeb};
      8'h08:   return {16'h0, hist[SYNC-1]};
      8'h0C:   return {16'h0, m_en};
      8'h10:   return {16'h0, m_stat};
      8'h14:   return {16'h0, m_edge};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_dout = '0; m_oeb = '1; m_en = '0; m_stat = '0; m_edge = '0; m_last_set = '0;
    for (int j = 0; j <= SYNC; j++) hist[j] = '0;
    b_off = 8'hFF;
    m_rd_exp = '0;
  endtask

  // One clock edge of the model: read snapshot, edge detection, input history.
  task automatic model_edge();
    logic [15:0] nv, ov, set;
    m_rd_exp = model_read(b_off);
    nv  = hist[SYNC-1];
    ov  = hist[SYNC];
    set = (nv & ~ov & ~m_edge) | (~nv & ov & m_edge);
    m_stat = m_stat | set;
    m_last_set = set;
    for (int j = SYNC; j > 0; j--) hist[j] = hist[j-1];
    hist[0] = io_in;
  endtask

  task automatic model_write(input logic [7:0] off, input logic [3:0] s, input logic [31:0] d);
    logic [15:0] mask, wd;
    mask = {{8{s[1]}}, {8{s[0]}}};
    wd   = d[15:0] & mask;
    case (off)
      8'h00: m_dout = (m_dout & ~mask) | wd;
      8'h04: m_oeb  = (m_oeb & ~mask) | wd;
      8'h0C: m_en   = (m_en & ~mask) | wd;
      8'h10: m_stat = (m_stat & ~wd) | m_last_set;
      8'h14: m_edge = (m_edge & ~mask) | wd;
      default: ;
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Single access; must be called 1 time unit after a rising edge with ack low.
  task automatic bus(input logic w, input logic [3:0] s, input logic [31:0] a,
                     input logic [31:0] d, output logic [31:0] r);
    cyc = 1'b1; stb = 1'b1; we = w; sel = s; adr = a; dat_i = d; b_off = a[7:0];
    tick();
    r = dat_o;
    vectors++;
    if (ack !== 1'b1) begin
      miscompares++;
      $display("FAIL ack_timing adr=%08h ack=%b required=1", a, ack);
    end else if (w) begin
      model_write(a[7:0], s, d);
    end
    $display("txn %s adr=%08h sel=%h wdat=%08h rdat=%08h", w ? "WR" : "RD", a, s, d, r);
    cyc = 1'b0; stb = 1'b0; we = 1'b0; b_off = 8'hFF;
  endtask

  task automatic wr(input logic [7:0] off, input logic [3:0] s, input logic [31:0] d);
    logic [31:0] r;
    bus(1'b1, s, BASE | {24'h0, off}, d, r);
    tick();
  endtask

  task automatic rd(input logic [7:0] off, output logic [31:0] r, output logic [31:0] e);
    bus(1'b0, 4'hF, BASE | {24'h0, off}, 32'h0, r);
    e = m_rd_exp;
    tick();
  endtask

  task automatic b5(input logic w, input logic [7:0] off, input logic [31:0] d, output logic [31:0] r);
    cyc5 = 1'b1; stb5 = 1'b1; we5 = w; sel5 = 4'hF; adr5 = BASE | {24'h0, off}; wdat5 = d;
    tick();
    r = rdat5;
    vectors++;
    if (ack5 !== 1'b1) begin
      miscompares++;
      $display("FAIL ack_timing_n5 off=%02h ack=%b required=1", off, ack5);
    end
    $display("txn5 %s off=%02h wdat=%08h rdat=%08h", w ? "WR" : "RD", off, d, r);
    cyc5 = 1'b0; stb5 = 1'b0; we5 = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    logic [7:0]  offs [5];
    logic [31:0] vals [5];
    logic [31:0] r, e;
    offs = '{8'h00, 8'h04, 8'h0C, 8'h10, 8'h14};
    vals = '{32'h0, 32'h0000FFFF, 32'h0, 32'h0, 32'h0};
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    tick();
    for (int i = 0; i < 5; i++) begin
      rd(offs[i], r, e);
      vectors++;
      if (r !== vals[i]) begin
        miscompares++;
        $display("FAIL reset_read off=%02h got=%08h required=%08h", offs[i], r, vals[i]);
      end
    end
    vectors++;
    if (io_oeb !== 16'hFFFF || io_out !== 16'h0 || irq !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_pads oeb=%h out=%h irq=%b required ffff/0000/0", io_oeb, io_out, irq);
    end
    // Reset in the middle of a write's ack cycle, then with the request still held.
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = BASE; dat_i = 32'h1234;
    tick();
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (ack !== 1'b0 || io_out !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_async ack=%b out=%h required 0/0000", ack, io_out);
    end
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (ack !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_hold_ack ack=%b required=0", ack);
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    rst = 1'b0;
    model_reset();
    tick();
    vectors++;
    if (io_out !== 16'h0 || ack !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_dropped_write out=%h ack=%b required 0000/0", io_out, ack);
    end
  endtask

  task automatic test_byte_lane();
    logic [31:0] r, e;
    wr(8'h00, 4'b0001, 32'h0000A5A5);
    rd(8'h00, r, e);
    vectors++;
    if (r !== 32'h000000A5 || io_out !== 16'h00A5) begin
      miscompares++;
      $display("FAIL byte_lane got=%08h out=%h required 000000a5/00a5", r, io_out);
    end
    bus(1'b1, 4'hF, BASE | 32'h04, 32'h0, r);
    vectors++;
    if (io_oeb !== 16'h0) begin
      miscompares++;
      $display("FAIL oeb_at_ack got=%h required=0000", io_oeb);
    end
    tick();
  endtask

  task automatic test_input_sync();
    logic [31:0] r, e;
    io_in[3] = 1'b1;
    for (int n = 0; n < 3; n++) begin
      rd(8'h08, r, e);
      vectors++;
      if (r !== e || r[3] !== (2 * n >= SYNC)) begin
        miscompares++;
        $display("FAIL input_sync poll=%0d got=%08h required=%08h", n, r, e);
      end
    end
  endtask

  task automatic test_edge_irq();
    logic [31:0] r, e;
    io_in = '0;
    repeat (SYNC + 2) tick();
    wr(8'h10, 4'hF, 32'hFFFF);
    wr(8'h14, 4'hF, 32'h0);
    wr(8'h0C, 4'hF, 32'h8);
    io_in[3] = 1'b1;
    for (int c = 1; c <= SYNC + 1; c++) begin
      tick();
      vectors++;
      if (irq !== (c == SYNC + 1)) begin
        miscompares++;
        $display("FAIL irq_timing edge=%0d irq=%b required=%b", c, irq, c == SYNC + 1);
      end
    end
    rd(8'h10, r, e);
    vectors++;
    if (r !== 32'h8) begin
      miscompares++;
      $display("FAIL irq_status_rise got=%08h required=00000008", r);
    end
    wr(8'h10, 4'hF, 32'h8);
    vectors++;
    if (irq !== 1'b0) begin
      miscompares++;
      $display("FAIL irq_w1c irq=%b required=0", irq);
    end
    wr(8'h14, 4'hF, 32'h8);
    repeat (2) tick();
    rd(8'h10, r, e);
    vectors++;
    if (r !== 32'h0) begin
      miscompares++;
      $display("FAIL edge_change_no_set got=%08h required=0", r);
    end
    io_in[3] = 1'b0;
    repeat (SYNC + 2) tick();
    rd(8'h10, r, e);
    vectors++;
    if (r !== 32'h8 || irq !== 1'b1) begin
      miscompares++;
      $display("FAIL irq_fall got=%08h irq=%b required 00000008/1", r, irq);
    end
    wr(8'h10, 4'hF, 32'h8);
    io_in[3] = 1'b1;
    repeat (SYNC + 2) tick();
    rd(8'h10, r, e);
    vectors++;
    if (r !== 32'h0 || irq !== 1'b0) begin
      miscompares++;
      $display("FAIL irq_rise_ignored got=%08h irq=%b required 0/0", r, irq);
    end
  endtask

  task automatic test_collision();
    logic [31:0] r, e;
    wr(8'h14, 4'hF, 32'h0);
    io_in[3] = 1'b0;
    repeat (SYNC + 2) tick();
    wr(8'h10, 4'hF, 32'hFFFF);
    io_in[3] = 1'b1;
    repeat (SYNC) tick();
    bus(1'b1, 4'hF, BASE | 32'h10, 32'h8, r);
    tick();
    rd(8'h10, r, e);
    vectors++;
    if (r !== 32'h8 || r !== e) begin
      miscompares++;
      $display("FAIL set_clear_collision got=%08h required=00000008", r);
    end
    wr(8'h10, 4'hF, 32'h8);
    rd(8'h10, r, e);
    vectors++;
    if (r !== 32'h0) begin
      miscompares++;
      $display("FAIL clear_after_collision got=%08h required=0", r);
    end
  endtask

  task automatic test_decode();
    logic [31:0] r, e;
    logic        seen;
    rd(8'h18, r, e);
    vectors++;
    if (r !== 32'h0) begin
      miscompares++;
      $display("FAIL unmapped_read got=%08h required=0", r);
    end
    cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = BASE + 32'h100;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (ack !== 1'b0) seen = 1'b1;
    end
    vectors++;
    if (seen) begin
      miscompares++;
      $display("FAIL miss_no_ack ack seen=1 required=0");
    end
    cyc = 1'b0; stb = 1'b0;
    tick();
    cyc = 1'b1; stb = 1'b1; adr = BASE | 32'h04; b_off = 8'h04;
    for (int c = 0; c < 6; c++) begin
      tick();
      vectors++;
      if (ack !== (c % 2 == 0) || (ack === 1'b1 && dat_o !== m_rd_exp)) begin
        miscompares++;
        $display("FAIL held_stb cycle=%0d ack=%b dat=%08h required %b/%08h",
                 c, ack, dat_o, c % 2 == 0, m_rd_exp);
      end
    end
    cyc = 1'b0; stb = 1'b0; b_off = 8'hFF;
    tick();
  endtask

  task automatic test_num_io5();
    logic [31:0] r;
    b5(1'b1, 8'h00, 32'hFFFF_FFFF, r);
    b5(1'b0, 8'h00, 32'h0, r);
    vectors++;
    if (r !== 32'h1F || io_out5 !== 5'h1F) begin
      miscompares++;
      $display("FAIL n5_dout got=%08h out=%h required 0000001f/1f", r, io_out5);
    end
    b5(1'b1, 8'h0C, 32'hFFFF_FFFF, r);
    b5(1'b0, 8'h0C, 32'h0, r);
    vectors++;
    if (r !== 32'h1F) begin
      miscompares++;
      $display("FAIL n5_irq_en got=%08h required=0000001f", r);
    end
  endtask

  task automatic test_random();
    logic [7:0]  offs [8];
    logic [31:0] r, e;
    logic [7:0]  off;
    offs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C};
    for (int i = 0; i < 150; i++) begin
      off = offs[$urandom_range(0, 7)];
      case ($urandom_range(0, 3))
        0: begin
          io_in = 16'($urandom);
          repeat ($urandom_range(0, 2)) tick();
        end
        1: wr(off, 4'($urandom), $urandom);
        default: begin
          rd(off, r, e);
          vectors++;
          if (r !== e) begin
            miscompares++;
            $display("FAIL rand_read iter=%0d off=%02h got=%08h required=%08h", i, off, r, e);
          end
        end
      endcase
      vectors++;
      if (io_out !== m_dout || io_oeb !== m_oeb || irq !== |(m_stat & m_en)) begin
        miscompares++;
        $display("FAIL rand_pads iter=%0d out=%h oeb=%h irq=%b required %h/%h/%b",
                 i, io_out, io_oeb, irq, m_dout, m_oeb, |(m_stat & m_en));
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = '0; dat_i = '0; io_in = '0;
    cyc5 = 1'b0; stb5 = 1'b0; we5 = 1'b0; sel5 = 4'h0; adr5 = '0; wdat5 = '0; io_in5 = '0;
    rst = 1'b1;
    model_reset();
    test_reset();
    test_byte_lane();
    test_input_sync();
    test_edge_irq();
    test_collision();
    test_decode();
    test_num_io5();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
